int_div_seq: RTL and testbench
==============================

Name: int_div_seq

Overview:
- Iterative multi-cycle sequencer for the RV32M divide group: DIV, DIVU, REM and REMU.
- Sits in the integer path of the execute stage, beside the single-cycle integer ALU, which keeps ADD..MULHU.
- Accepts one operation through a valid/ready handshake and runs a radix-2 restoring divide over DATA_WIDTH cycles.
- Handles the RISC-V corner cases (divide-by-zero, signed overflow) in a short path, then holds the result until the writeback side accepts it.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- TAG_WIDTH, 5, width of the opaque tag (destination register index) carried alongside the operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept a request; high only in IDLE.
- op_i  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a_i  input  DATA_WIDTH  dividend.
- b_i  input  DATA_WIDTH  divisor.
- tag_i  input  TAG_WIDTH  tag captured with the request.
- flush_i  input  1  kill any in-flight or pending operation.
- resp_valid_o  output  1  result available.
- resp_ready_i  input  1  consumer accepts the result.
- result_o  output  DATA_WIDTH  quotient or remainder, selected by op.
- tag_o  output  TAG_WIDTH  tag of the result.
- busy_o  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - resp_valid_o=0, result_o=0, tag_o=0, busy_o=0, all internal registers 0.
  - req_ready_o=1 once in IDLE.
- Handshake:
  - Request accepted in a cycle where req_valid_i && req_ready_o && !flush_i.
  - Response completes in a cycle where resp_valid_o && resp_ready_i.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept of a normal operation.
  - IDLE -> DONE on accept of a special case.
  - CALC -> FIX after DATA_WIDTH iterations.
  - FIX -> DONE.
  - DONE -> IDLE on response handshake.
  - A new request is never accepted in the same cycle as the response handshake.
- On accept, register op, tag, sign flags and operand magnitudes:
  - Magnitudes are absolute values for DIV/REM and raw values for DIVU/REMU.
  - Iteration counter is set to DATA_WIDTH-1.
- CALC, each cycle:
  - Shift remainder:dividend left by one.
  - Trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - Counter decrements; leave CALC when the counter is 0.
- FIX:
  - Quotient is negated if sign(a) != sign(b) (signed ops only).
  - Remainder takes the sign of a (signed ops only).
  - result_o is loaded with the quotient or remainder per op, and tag_o is loaded.
- Latency for a normal operation, with the accept cycle as cycle 0:
  - CALC occupies cycles 1..DATA_WIDTH.
  - FIX is cycle DATA_WIDTH+1.
  - resp_valid_o is high from cycle DATA_WIDTH+2 (34 at default).
- Special cases take the short path: resp_valid_o is high in cycle 1.
  - b=0: quotient = all ones (-1), remainder = a, for both signed and unsigned.
  - Signed overflow (DIV/REM, a = most-negative value, b = -1): quotient = a, remainder = 0.
- DONE:
  - resp_valid_o, result_o and tag_o are held stable until resp_ready_i.
  - resp_valid_o drops in the cycle after the handshake.
- flush_i:
  - Highest priority; from any state, next state is IDLE and resp_valid_o=0 next cycle.
  - A request presented in the same cycle as flush_i is not accepted.
  - result_o and tag_o are not cleared by flush.
- Reset asserted mid-operation aborts immediately to reset values; nothing is retained.
- busy_o = (state != IDLE).

Decomposition:
- Package int_div_pkg holds:
  - typedef enum div_op_e {DIV, DIVU, REM, REMU} (2 bits).
  - typedef enum div_state_e {IDLE, CALC, FIX, DONE}.
  - Function is_special(op, a, b).
- One natural sub-module, div_iter_step: a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- int_div_seq owns the FSM, counter, sign handling and handshake.

Test Plan:
- DIVU a=100 b=7 -> resp_valid_o first high in cycle 34, result_o=14. Same with REMU -> 2.
- DIV a=-7 b=2 -> result_o=-3 (0xFFFFFFFD). REM -> -1 (0xFFFFFFFF). DIV a=7 b=-2 -> 0xFFFFFFFD.
- Divide-by-zero:
  - DIV a=5 b=0 -> cycle 1 result_o=0xFFFFFFFF.
  - REMU a=5 b=0 -> result_o=5.
  - Overflow: DIV a=0x80000000 b=0xFFFFFFFF -> result_o=0x80000000; REM -> 0.
- Backpressure: hold resp_ready_i=0 for 10 cycles after completion.
  - resp_valid_o, result_o and tag_o stay constant; req_ready_o stays 0.
  - Release -> one handshake, IDLE next cycle.
- flush_i asserted in CALC cycle 10 -> IDLE next cycle, resp_valid_o never rises. A new DIVU 9/3 then returns 3 with its own tag.
- Reset asserted during CALC -> all outputs at reset values asynchronously, req_ready_o=1 after release.

Source files
------------

// File: rtl/int_div_pkg.sv
// Shared types and helpers for the RV32M iterative divide unit.
package int_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Operands arrive zero-extended to 64 bits so one helper serves any width up to 64.
    function automatic logic is_special(div_op_e op, logic [63:0] a, logic [63:0] b, int width);
        logic [63:0] w_msb;
        logic [63:0] w_ones;
        logic        w_signed;
        w_msb    = 64'd1 << (width - 1);
        w_ones   = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        w_signed = (op == DIV) || (op == REM);
        is_special = (b == 64'd0) || (w_signed && (a == w_msb) && (b == w_ones));
    endfunction

endpackage

// File: rtl/int_div_iter_step.sv
// One radix-2 restoring divide step: shift in the next dividend bit, trial-subtract the divisor.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so the top bit of the difference is its sign.
    assign w_shift = {rem_i, bit_i};
    assign w_diff  = w_shift - {1'b0, divisor_i};
    assign q_o     = ~w_diff[WIDTH];
    assign rem_o   = q_o ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/int_div_seq.sv
// Iterative DIV/DIVU/REM/REMU sequencer with valid/ready request and response handshakes.
module int_div_seq
    import int_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  flush_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    div_state_e            r_state;
    div_op_e               r_op;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DATA_WIDTH-1:0] r_dvd;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [TAG_WIDTH-1:0]  r_tag_out;
    logic                  r_resp_valid;

    div_op_e               w_op;
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_accept;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_special_q;
    logic [DATA_WIDTH-1:0] w_special_r;
    logic [DATA_WIDTH-1:0] w_special_result;
    logic [DATA_WIDTH-1:0] w_step_rem;
    logic                  w_step_q;
    logic [DATA_WIDTH-1:0] w_quot_fix;
    logic [DATA_WIDTH-1:0] w_rem_fix;

    assign w_op     = div_op_e'(op_i);
    assign w_signed = (w_op == DIV) || (w_op == REM);
    assign w_a_neg  = w_signed && a_i[DATA_WIDTH-1];
    assign w_b_neg  = w_signed && b_i[DATA_WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a_i : a_i;
    assign w_b_mag  = w_b_neg ? -b_i : b_i;
    assign w_accept = req_valid_i && req_ready_o && !flush_i;

    // Divide-by-zero and signed overflow bypass the iteration and complete straight from IDLE.
    assign w_special        = is_special(w_op, 64'(a_i), 64'(b_i), DATA_WIDTH);
    assign w_special_q      = (b_i == '0) ? '1 : a_i;
    assign w_special_r      = (b_i == '0) ? a_i : '0;
    assign w_special_result = op_i[1] ? w_special_r : w_special_q;

    assign w_quot_fix = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    div_iter_step #(
        .WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_i    (r_rem),
        .bit_i    (r_dvd[DATA_WIDTH-1]),
        .divisor_i(r_div),
        .rem_o    (w_step_rem),
        .q_o      (w_step_q)
    );

    assign req_ready_o  = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign resp_valid_o = r_resp_valid;
    assign result_o     = r_result;
    assign tag_o        = r_tag_out;

    // The dividend register doubles as the quotient: quotient bits shift in as dividend bits shift out.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_op         <= DIV;
            r_tag        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dvd        <= '0;
            r_div        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_tag_out    <= '0;
            r_resp_valid <= 1'b0;
        end else if (flush_i) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_tag   <= tag_i;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dvd   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(DATA_WIDTH - 1);
                        if (w_special) begin
                            r_result     <= w_special_result;
                            r_tag_out    <= tag_i;
                            r_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_step_q};
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    r_result     <= ((r_op == REM) || (r_op == REMU)) ? w_rem_fix : w_quot_fix;
                    r_tag_out    <= r_tag;
                    r_resp_valid <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_seq.sv
// Directed bench for int_div_seq: a reference model fills a scoreboard queue, responses pop and compare.
module tb_int_div_seq;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  tag_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] result_o;
    logic [4:0]  tag_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    int_div_seq #(
        .DATA_WIDTH(32),
        .TAG_WIDTH (5)
    ) dut (
        .clk         (clk),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .tag_i       (tag_i),
        .flush_i     (flush_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic refSpecial(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] refModel(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge of cycle 1 (accept cycle is cycle 0).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
        int guard;
        exp_t e;
        guard = 0;
        while (!req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkValue("req_ready_before_issue", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        op_i        = op;
        a_i         = a;
        b_i         = b;
        tag_i       = tag;
        e.res = refModel(op, a, b);
        e.tag = tag;
        e.lat = refSpecial(op, a, b) ? 1 : 34;
        sbQ.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Waits (bounded) for the response, compares it to the scoreboard head, optionally stalls, then handshakes.
    task automatic checkOutput(input string name, input int holdCycles);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!resp_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkValue({name, "_valid"}, 32'(resp_valid_o), 32'd1);
        if (sbQ.size() == 0) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL %s_scoreboard: observed empty queue expected an entry", name);
        end else begin
            e = sbQ.pop_front();
            checkValue({name, "_latency"}, 32'(cyc), 32'(e.lat));
            checkValue({name, "_result"}, result_o, e.res);
            checkValue({name, "_tag"}, 32'(tag_o), 32'(e.tag));
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                checkValue({name, "_hold_valid"}, 32'(resp_valid_o), 32'd1);
                checkValue({name, "_hold_result"}, result_o, e.res);
                checkValue({name, "_hold_tag"}, 32'(tag_o), 32'(e.tag));
                checkValue({name, "_hold_req_ready"}, 32'(req_ready_o), 32'd0);
            end
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        checkValue({name, "_valid_drop"}, 32'(resp_valid_o), 32'd0);
        checkValue({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int          sawValid;
        exp_t        dropped;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n_i      = 1'b1;
        req_valid_i  = 1'b0;
        op_i         = 2'b00;
        a_i          = '0;
        b_i          = '0;
        tag_i        = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        #1 rst_n_i = 1'b0;
        #2;
        $display("[TB] reset state");
        checkValue("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkValue("rst_result", result_o, 32'd0);
        checkValue("rst_tag", 32'(tag_o), 32'd0);
        checkValue("rst_busy", 32'(busy_o), 32'd0);
        checkValue("rst_req_ready", 32'(req_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus(2'b01, 32'd100, 32'd7, 5'd1);
        checkOutput("divu_100_7", 0);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd2);
        checkOutput("remu_100_7", 0);
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
        checkOutput("div_m7_2", 0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
        checkOutput("rem_m7_2", 0);
        applyStimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd5);
        checkOutput("div_7_m2", 0);
        applyStimulus(2'b00, 32'd5, 32'd0, 5'd6);
        checkOutput("div_by_zero", 0);
        applyStimulus(2'b11, 32'd5, 32'd0, 5'd7);
        checkOutput("remu_by_zero", 0);
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        checkOutput("div_overflow", 0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        checkOutput("rem_overflow", 0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd10);
        checkOutput("divu_max_1", 0);

        $display("[TB] random operations");
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            applyStimulus(rop, ra, rb, 5'(11 + i));
            checkOutput("random_op", 0);
        end

        $display("[TB] backpressure");
        applyStimulus(2'b01, 32'd1000, 32'd10, 5'd20);
        checkOutput("backpressure", 10);

        $display("[TB] flush during CALC");
        applyStimulus(2'b01, 32'h0000_FFFF, 32'd3, 5'd21);
        dropped = sbQ.pop_back();
        repeat (9) @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        op_i        = 2'b01;
        a_i         = 32'd50;
        b_i         = 32'd5;
        tag_i       = 5'd22;
        @(negedge clk);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        checkValue("flush_busy", 32'(busy_o), 32'd0);
        checkValue("flush_resp_valid", 32'(resp_valid_o), 32'd0);
        checkValue("flush_req_ready", 32'(req_ready_o), 32'd1);
        checkValue("flush_result_kept", result_o, 32'd100);
        checkValue("flush_tag_kept", 32'(tag_o), 32'd20);
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid_o) sawValid++;
        end
        checkValue("flush_no_response", 32'(sawValid), 32'd0);
        applyStimulus(2'b01, 32'd9, 32'd3, 5'd23);
        checkOutput("after_flush_divu_9_3", 0);

        $display("[TB] reset during CALC");
        applyStimulus(2'b01, 32'd12345, 32'd67, 5'd24);
        dropped = sbQ.pop_back();
        repeat (4) @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        checkValue("midrst_resp_valid", 32'(resp_valid_o), 32'd0);
        checkValue("midrst_result", result_o, 32'd0);
        checkValue("midrst_tag", 32'(tag_o), 32'd0);
        checkValue("midrst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        #1;
        checkValue("midrst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        applyStimulus(2'b10, 32'd50, 32'hFFFF_FFF9, 5'd25);
        checkOutput("after_reset_rem_50_m7", 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
